fc_head: RTL and testbench

- Final classifier stage, directly downstream of the two-layer convolution block.
- Consumes one OUT2_H x OUT2_W signed 24-bit feature map per channel, announced by a one-cycle valid and a channel index.
- Applies ReLU to each element, then multiply-accumulates the map against the per-channel fully-connected weight slice, one element per cycle.
- Sums the result across all CHAN channels and emits one signed score per image.

---
 rtl/fc_head.sv | 144 ++++++++++++++
 tb/tb_fc_head.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_head.sv
// Fully-connected classifier head: ReLU on each feature-map element, MAC against the
// per-channel weight slice one element per cycle, and a sum over all channels into one image score.
module fc_head #(
    parameter int H     = 12,
    parameter int W     = 11,
    parameter int CHAN  = 10,
    parameter int IN_W  = 24,
    parameter int ACC_W = 44
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [3:0]              in_chan,
    input  logic signed [IN_W-1:0]  in_map [0:H-1][0:W-1],
    input  logic signed [7:0]       w_fc   [0:H-1][0:W-1][0:CHAN-1],
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] score,
    output logic                    score_valid,
    output logic                    err_overrun,
    output logic                    err_chan
);

    localparam int ROW_W  = $clog2(H);
    localparam int COL_W  = $clog2(W);
    localparam int PROD_W = IN_W + 9;

    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(H - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(W - 1);
    localparam logic [3:0]       CHAN_LIM  = 4'(CHAN);
    localparam logic [3:0]       CHAN_LAST = 4'(CHAN - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [3:0]              chan_q, chan_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] score_q, score_d;
    logic                    score_valid_q, score_valid_d;
    logic                    err_overrun_q, err_overrun_d;
    logic                    err_chan_q, err_chan_d;
    logic signed [IN_W-1:0]  map_buf_q [0:H-1][0:W-1];
    logic signed [IN_W-1:0]  map_buf_d [0:H-1][0:W-1];

    logic signed [IN_W-1:0]   elem;
    logic signed [IN_W-1:0]   relu_val;
    logic signed [PROD_W-1:0] prod;

    assign in_ready = (state_q == IDLE);

    always_comb begin
        elem     = map_buf_q[row_q][col_q];
        relu_val = elem[IN_W-1] ? '0 : elem;
        prod     = PROD_W'(relu_val) * PROD_W'(w_fc[row_q][col_q][chan_q]);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        chan_d        = chan_q;
        acc_d         = acc_q;
        score_d       = score_q;
        score_valid_d = 1'b0;
        err_overrun_d = err_overrun_q;
        err_chan_d    = err_chan_q;
        map_buf_d     = map_buf_q;

        if (in_valid && !in_ready) err_overrun_d = 1'b1;
        if (in_valid && (in_chan >= CHAN_LIM)) err_chan_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (in_valid && (in_chan < CHAN_LIM)) begin
                    map_buf_d = in_map;
                    chan_d    = in_chan;
                    row_d     = '0;
                    col_d     = '0;
                    if (in_chan == 4'd0) acc_d = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = (chan_q == CHAN_LAST) ? DONE : IDLE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            DONE: begin
                score_d       = acc_q;
                score_valid_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            chan_q        <= '0;
            acc_q         <= '0;
            score_q       <= '0;
            score_valid_q <= 1'b0;
            err_overrun_q <= 1'b0;
            err_chan_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            chan_q        <= chan_d;
            acc_q         <= acc_d;
            score_q       <= score_d;
            score_valid_q <= score_valid_d;
            err_overrun_q <= err_overrun_d;
            err_chan_q    <= err_chan_d;
        end
    end

    // NOTE: the map buffer is pure data that is always written before it is read, so it has no reset.
    always_ff @(posedge clk) begin
        map_buf_q <= map_buf_d;
    end

    assign score       = score_q;
    assign score_valid = score_valid_q;
    assign err_overrun = err_overrun_q;
    assign err_chan    = err_chan_q;

endmodule

// File: tb/tb_fc_head.sv
// Directed bench for fc_head: table of whole-image vectors plus hand-written
// sequences for overrun, bad channel index and reset in the middle of a MAC.
module tb_fc_head;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic [3:0]         in_chan;
    logic signed [23:0] in_map [0:11][0:10];
    logic signed [7:0]  w_fc   [0:11][0:10][0:9];
    logic               in_ready;
    logic signed [43:0] score;
    logic               score_valid;
    logic               err_overrun;
    logic               err_chan;

    fc_head dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_chan     (in_chan),
        .in_map      (in_map),
        .w_fc        (w_fc),
        .in_ready    (in_ready),
        .score       (score),
        .score_valid (score_valid),
        .err_overrun (err_overrun),
        .err_chan    (err_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string              name;
        logic signed [23:0] map_v;
        logic signed [7:0]  w_v;
        logic signed [23:0] corner;
        bit                 w_by_chan;
        logic signed [63:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fill(input logic signed [23:0] mv, input logic signed [7:0] wv,
                            input logic signed [23:0] corner, input bit w_by_chan);
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 11; c++) begin
                in_map[r][c] = mv;
                for (int k = 0; k < 10; k++)
                    w_fc[r][c][k] = w_by_chan ? 8'(k + 1) : wv;
            end
        in_map[0][0] = corner;
    endtask

    // Waits (bounded) for in_ready, then pulses in_valid for one edge; returns #1 after that edge.
    task automatic send(input logic [3:0] ch);
        int n = 0;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_chan  = ch;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_image(input string tag, input int first, input logic signed [63:0] exp);
        int lat = 0;
        for (int k = first; k < 10; k++) send(4'(k));
        while (!score_valid && lat < 300) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 133);
        check({tag, "_score"}, score, exp);
        tick();
        check({tag, "_pulse_len"}, score_valid, 0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int seen;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_chan  = '0;
        set_fill(24'sd0, 8'sd0, 24'sd0, 1'b0);

        vecs[0] = '{"ones",   24'sd1,       8'sd1,    24'sd1,       1'b0, 64'sd1320};
        vecs[1] = '{"relu",   24'sd0,       8'sd127,  -24'sd5000,   1'b0, 64'sd0};
        vecs[2] = '{"maxneg", 24'sd8388607, -8'sd128, 24'sd8388607, 1'b0, -64'sd1417339038720};
        vecs[3] = '{"mixed",  24'sd3,       -8'sd2,   24'sd7,       1'b0, -64'sd8000};
        vecs[4] = '{"chansl", 24'sd1,       8'sd0,    24'sd1,       1'b1, 64'sd7260};

        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_score", score, 0);
        check("rst_score_valid", score_valid, 0);
        check("rst_err_overrun", err_overrun, 0);
        check("rst_err_chan", err_chan, 0);

        for (int i = 0; i < 5; i++) begin
            set_fill(vecs[i].map_v, vecs[i].w_v, vecs[i].corner, vecs[i].w_by_chan);
            run_image(vecs[i].name, 0, vecs[i].exp);
        end

        // Out-of-range channel: flagged, ignored, then a normal image.
        do_reset();
        set_fill(24'sd1, 8'sd1, 24'sd1, 1'b0);
        in_valid = 1'b1;
        in_chan  = 4'd12;
        tick();
        in_valid = 1'b0;
        check("badch_err_chan", err_chan, 1);
        check("badch_in_ready", in_ready, 1);
        repeat (3) tick();
        check("badch_no_mac", in_ready, 1);
        check("badch_no_overrun", err_overrun, 0);
        send(4'd0);
        n = 0;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        check("ready_latency_nonlast", n, 132);
        run_image("badch", 1, 64'sd1320);

        // Overrun during channel-3 MAC with the map changed underneath: no effect on the score.
        do_reset();
        set_fill(24'sd1, 8'sd1, 24'sd1, 1'b0);
        for (int k = 0; k < 4; k++) send(4'(k));
        repeat (19) tick();
        set_fill(24'sd1000, 8'sd1, 24'sd1000, 1'b0);
        in_valid = 1'b1;
        in_chan  = 4'd5;
        tick();
        in_valid = 1'b0;
        check("ovr_err_overrun", err_overrun, 1);
        check("ovr_err_chan", err_chan, 0);
        set_fill(24'sd1, 8'sd1, 24'sd1, 1'b0);
        run_image("ovr", 4, 64'sd1320);

        // Reset in the middle of the channel-9 MAC.
        run_image("prerst", 0, 64'sd1320);
        for (int k = 0; k < 10; k++) send(4'(k));
        repeat (59) tick();
        rst = 1'b1;
        #1;
        check("midrst_score", score, 0);
        check("midrst_score_valid", score_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_err_overrun", err_overrun, 0);
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (score_valid) seen++;
        end
        check("midrst_no_pulse", seen, 0);
        check("midrst_score_held", score, 0);
        set_fill(24'sd1, 8'sd2, 24'sd1, 1'b0);
        run_image("postrst", 0, 64'sd2640);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
